// File: rtl/cpu_pkg.sv
// Shared definitions for the LoongArch pipeline: op indices, bus widths,
// divider state encoding and a small two's-complement helper.
package cpu_pkg;

    localparam int ALU_OP_W = 12;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    localparam int MD_OP_W    = 7;
    localparam int MD_MUL_W   = 0;
    localparam int MD_MULH_W  = 1;
    localparam int MD_MULH_WU = 2;
    localparam int MD_DIV_W   = 3;
    localparam int MD_MOD_W   = 4;
    localparam int MD_DIV_WU  = 5;
    localparam int MD_MOD_WU  = 6;

    localparam int ST_W = 0;
    localparam int ST_H = 1;
    localparam int ST_B = 2;

    localparam int EX_RF_BUS_W  = 40;
    localparam int EXCEPT_BUS_W = 82;
    localparam int EX_FWD_BUS_W = 39;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider: magnitudes in, one quotient bit per
// cycle, sign fix-up applied on the registered magnitudes while in DONE.
module ex_div
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        flush,
    input  logic        signed_op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] q,
    output logic [31:0] r,
    output logic        done
);

    div_state_t  state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] quo, rem, dvs;
    logic        q_neg, r_neg, div0;
    logic [32:0] partial, sub;
    logic        fits;

    // remainder stays below the divisor, so the 33-bit difference sign is exact
    assign partial = {rem, quo[31]};
    assign sub     = partial - {1'b0, dvs};
    assign fits    = ~sub[32];

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (start) state_nxt = DIV_RUN;
            DIV_RUN:  if (cnt == 5'd31) state_nxt = DIV_DONE;
            DIV_DONE: state_nxt = DIV_DONE;
            default:  state_nxt = DIV_IDLE;
        endcase
        if (flush) state_nxt = DIV_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= DIV_IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == DIV_RUN) ? cnt + 5'd1 : 5'd0;
        end
    end

    // operand load / iteration
    always_ff @(posedge clk) begin
        if (state == DIV_IDLE && start) begin
            quo   <= neg_if(x, signed_op & x[31]);
            dvs   <= neg_if(y, signed_op & y[31]);
            rem   <= 32'd0;
            q_neg <= signed_op & (x[31] ^ y[31]);
            r_neg <= signed_op & x[31];
            div0  <= (y == 32'd0);
        end else if (state == DIV_RUN) begin
            quo <= {quo[30:0], fits};
            rem <= fits ? sub[31:0] : partial[31:0];
        end
    end

    // with a zero divisor rem accumulates |x|, so the fix-up restores the dividend
    assign done = (state == DIV_DONE);
    assign q    = div0 ? 32'hFFFF_FFFF : neg_if(quo, q_neg);
    assign r    = neg_if(rem, r_neg);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, multiply, divide and data-SRAM request issue.
// EX_ITER_DIV_EN selects the iterative ex_div; otherwise divide is combinational.
module ex_stage
    import cpu_pkg::*;
(
    input  logic                    clk,
    input  logic                    resetn,
    output logic                    EX_allowin,
    input  logic                    ID_EX_valid,
    input  logic [31:0]             ID_pc,
    input  logic [ALU_OP_W-1:0]     ID_alu_op,
    input  logic [MD_OP_W-1:0]      ID_md_op,
    input  logic [31:0]             ID_src1,
    input  logic [31:0]             ID_src2,
    input  logic [31:0]             ID_st_data,
    input  logic [2:0]              ID_st_op,
    input  logic [12:0]             ID_ctrl,
    input  logic [EXCEPT_BUS_W-1:0] ID_except_bus,
    input  logic                    MEM_allowin,
    output logic                    EX_MEM_valid,
    output logic [31:0]             EX_pc,
    output logic [EX_RF_BUS_W-1:0]  EX_rf_bus,
    output logic [4:0]              EX_mem_ld_inst,
    output logic [EXCEPT_BUS_W-1:0] EX_except_bus,
    output logic [EX_FWD_BUS_W-1:0] EX_fwd_bus,
    input  logic                    MEM_EXC_signal,
    input  logic                    WB_EXC_signal,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_we,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    logic                    vld_p0;
    logic [31:0]             pc_p0, src1_p0, src2_p0, st_data_p0;
    logic [ALU_OP_W-1:0]     alu_op_p0;
    logic [MD_OP_W-1:0]      md_op_p0;
    logic [2:0]              st_op_p0;
    logic [12:0]             ctrl_p0;
    logic [EXCEPT_BUS_W-1:0] except_p0;
    logic                    ready_go;

    assign EX_allowin   = ~vld_p0 | (ready_go & MEM_allowin);
    assign EX_MEM_valid = vld_p0 & ready_go;

    // ID -> EX boundary
    always_ff @(posedge clk) begin
        if (!resetn)
            vld_p0 <= 1'b0;
        else if (WB_EXC_signal)
            vld_p0 <= 1'b0;
        else if (EX_allowin)
            vld_p0 <= ID_EX_valid;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_p0      <= '0;
            src1_p0    <= '0;
            src2_p0    <= '0;
            st_data_p0 <= '0;
            alu_op_p0  <= '0;
            md_op_p0   <= '0;
            st_op_p0   <= '0;
            ctrl_p0    <= '0;
            except_p0  <= '0;
        end else if (ID_EX_valid & EX_allowin) begin
            pc_p0      <= ID_pc;
            src1_p0    <= ID_src1;
            src2_p0    <= ID_src2;
            st_data_p0 <= ID_st_data;
            alu_op_p0  <= ID_alu_op;
            md_op_p0   <= ID_md_op;
            st_op_p0   <= ID_st_op;
            ctrl_p0    <= ID_ctrl;
            except_p0  <= ID_except_bus;
        end
    end

    logic signed [31:0] s1, s2;
    logic        [31:0] alu_res;

    assign s1 = src1_p0;
    assign s2 = src2_p0;

    always_comb begin
        alu_res = 32'd0;
        if (alu_op_p0[ALU_ADD])  alu_res = src1_p0 + src2_p0;
        if (alu_op_p0[ALU_SUB])  alu_res = src1_p0 - src2_p0;
        if (alu_op_p0[ALU_SLT])  alu_res = {31'd0, s1 < s2};
        if (alu_op_p0[ALU_SLTU]) alu_res = {31'd0, src1_p0 < src2_p0};
        if (alu_op_p0[ALU_AND])  alu_res = src1_p0 & src2_p0;
        if (alu_op_p0[ALU_NOR])  alu_res = ~(src1_p0 | src2_p0);
        if (alu_op_p0[ALU_OR])   alu_res = src1_p0 | src2_p0;
        if (alu_op_p0[ALU_XOR])  alu_res = src1_p0 ^ src2_p0;
        if (alu_op_p0[ALU_SLL])  alu_res = src1_p0 << src2_p0[4:0];
        if (alu_op_p0[ALU_SRL])  alu_res = src1_p0 >> src2_p0[4:0];
        if (alu_op_p0[ALU_SRA])  alu_res = s1 >>> src2_p0[4:0];
        if (alu_op_p0[ALU_LUI])  alu_res = src2_p0;
    end

    // 33x33 signed multiply, carried at 64 bits since only 64 product bits are used
    logic               mul_sx;
    logic signed [63:0] mul_a, mul_b, mul_p;
    logic        [31:0] mul_res;

    assign mul_sx  = ~md_op_p0[MD_MULH_WU];
    assign mul_a   = {{32{mul_sx & src1_p0[31]}}, src1_p0};
    assign mul_b   = {{32{mul_sx & src2_p0[31]}}, src2_p0};
    assign mul_p   = mul_a * mul_b;
    assign mul_res = md_op_p0[MD_MUL_W] ? mul_p[31:0] : mul_p[63:32];

    logic        is_mul, is_div, div_signed, div_rem_sel;
    logic [31:0] div_q, div_r, result;

    assign is_mul      = |md_op_p0[MD_MULH_WU:MD_MUL_W];
    assign is_div      = |md_op_p0[MD_MOD_WU:MD_DIV_W];
    assign div_signed  = md_op_p0[MD_DIV_W] | md_op_p0[MD_MOD_W];
    assign div_rem_sel = md_op_p0[MD_MOD_W] | md_op_p0[MD_MOD_WU];

`ifdef EX_ITER_DIV_EN
    logic div_done;

    // flushing on handoff returns the divider to IDLE so a following divide restarts cleanly
    ex_div u_ex_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (vld_p0 & is_div),
        .flush     (WB_EXC_signal | (div_done & MEM_allowin)),
        .signed_op (div_signed),
        .x         (src1_p0),
        .y         (src2_p0),
        .q         (div_q),
        .r         (div_r),
        .done      (div_done)
    );

    assign ready_go = ~is_div | div_done;
`else
    function automatic logic [63:0] div_comb(input logic [31:0] x, input logic [31:0] y,
                                             input logic sgn);
        logic [31:0] xm, ym;
        if (y == 32'd0)
            return {32'hFFFF_FFFF, x};
        xm = neg_if(x, sgn & x[31]);
        ym = neg_if(y, sgn & y[31]);
        return {neg_if(xm / ym, sgn & (x[31] ^ y[31])), neg_if(xm % ym, sgn & x[31])};
    endfunction

    assign {div_q, div_r} = div_comb(src1_p0, src2_p0, div_signed);
    assign ready_go       = 1'b1;
`endif

    assign result = is_mul ? mul_res : (is_div ? (div_rem_sel ? div_r : div_q) : alu_res);

    logic [3:0]  st_mask;
    logic [31:0] st_wdata;
    logic        is_load, is_store, kill;

    always_comb begin
        st_mask  = 4'h0;
        st_wdata = st_data_p0;
        if (st_op_p0[ST_B]) begin
            st_mask  = 4'b0001 << result[1:0];
            st_wdata = {4{st_data_p0[7:0]}};
        end else if (st_op_p0[ST_H]) begin
            st_mask  = 4'b0011 << result[1:0];
            st_wdata = {2{st_data_p0[15:0]}};
        end else if (st_op_p0[ST_W]) begin
            st_mask  = 4'hF;
        end
    end

    assign is_load  = |ctrl_p0[4:0];
    assign is_store = |st_op_p0;
    assign kill     = except_p0[2] | MEM_EXC_signal | WB_EXC_signal;

    assign data_sram_en    = vld_p0 & (is_load | is_store) & ~kill;
    assign data_sram_we    = (vld_p0 & is_store & ~kill) ? st_mask : 4'h0;
    assign data_sram_addr  = result;
    assign data_sram_wdata = st_wdata;

    assign EX_pc          = pc_p0;
    assign EX_rf_bus      = {ctrl_p0[12:5], result};
    assign EX_mem_ld_inst = ctrl_p0[4:0];
    assign EX_except_bus  = except_p0;
    assign EX_fwd_bus     = {(ctrl_p0[12] | ctrl_p0[11]) & vld_p0, ctrl_p0[10] & vld_p0,
                             ctrl_p0[9:5], result};

endmodule
